// File: rtl/color_mode_sequencer_if.sv
// Direct mode-select handshake between a requester and the colour mode sequencer.
interface color_mode_sequencer_if;
   logic       sel_req_valid;
   logic [2:0] sel_req_mode;
   logic       sel_req_ready;

   modport master (
      output sel_req_valid,
      output sel_req_mode,
      input  sel_req_ready
   );

   modport slave (
      input  sel_req_valid,
      input  sel_req_mode,
      output sel_req_ready
   );
endinterface

// File: rtl/color_mode_sequencer.sv
// Colour mode sequencer: chooses the mode code for the colour datapath, defers
// every mode change to the next frame start and blanks the output while the
// downstream colour pipeline still holds pixels from the old mode.
module color_mode_sequencer #(
   parameter int NUM_MODES       = 7,
   parameter int FRAMES_PER_MODE = 60,
   parameter int FLUSH_CYCLES    = 3
) (
   input  logic                          clk_in,
   input  logic                          rst_n_in,
   input  logic                          rec_valid,
   input  logic [10:0]                   rec_hcount,
   input  logic [9:0]                    rec_vcount,
   input  logic                          btn_pulse_in,
   input  logic                          auto_en_in,
   color_mode_sequencer_if.slave         sel_req,
   output logic [2:0]                    selector_out,
   output logic                          blank_out,
   output logic                          pending_out,
   output logic                          err_pulse_out
);

   localparam int             FW         = $clog2(FLUSH_CYCLES + 1);
   localparam logic [FW-1:0]  FLUSH_INIT = FW'(FLUSH_CYCLES);
   localparam logic [2:0]     MODE_LAST  = 3'(NUM_MODES - 1);
   localparam logic [7:0]     FRAME_LAST = 8'(FRAMES_PER_MODE - 1);

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      PENDING = 2'd1,
      FLUSH   = 2'd2
   } state_t;

   state_t        r_state,    w_stateNext;
   logic [2:0]    r_selector, w_selectorNext;
   logic [2:0]    r_nextMode, w_nextModeNext;
   logic [2:0]    w_target;
   logic [FW-1:0] r_flushCnt, w_flushCntNext;
   logic [7:0]    r_frameCnt, w_frameCntNext;
   logic          r_ready,    w_readyNext;
   logic          r_err,      w_errNext;

   logic          w_sof;
   logic          w_dirAccept;
   logic          w_dirLegal;
   logic          w_frameWrap;
   logic          w_autoReq;

   // Next mode in the cycle order, wrapping the last legal code back to zero.
   function automatic logic [2:0] advance(input logic [2:0] m);
      return (m == MODE_LAST) ? 3'd0 : m + 3'd1;
   endfunction

   // Frame start is the first valid beat of row 0, column 0; the stream is
   // otherwise only observed, never forwarded.
   assign w_sof       = rec_valid && (rec_hcount == 11'd0) && (rec_vcount == 10'd0);
   assign w_dirAccept = sel_req.sel_req_valid && r_ready;
   assign w_dirLegal  = (32'(sel_req.sel_req_mode) < NUM_MODES);
   assign w_frameWrap = auto_en_in && (r_frameCnt == FRAME_LAST);
   // The auto request fires on the same frame start that wraps the counter,
   // so it only lands in PENDING and is applied one frame later.
   assign w_autoReq   = w_sof && (r_state == HOLD) && w_frameWrap;
   assign w_readyNext = (w_stateNext != FLUSH);

   assign selector_out          = r_selector;
   assign blank_out             = (r_state == FLUSH);
   assign pending_out           = (r_state == PENDING);
   assign err_pulse_out         = r_err;
   assign sel_req.sel_req_ready = r_ready;

   // State and datapath registers; reset aborts any change in flight at once.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state    <= HOLD;
         r_selector <= 3'd0;
         r_nextMode <= 3'd0;
         r_flushCnt <= '0;
         r_frameCnt <= 8'd0;
         r_ready    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_selector <= w_selectorNext;
         r_nextMode <= w_nextModeNext;
         r_flushCnt <= w_flushCntNext;
         r_frameCnt <= w_frameCntNext;
         r_ready    <= w_readyNext;
         r_err      <= w_errNext;
      end
   end

   // Request arbitration (direct over button over auto), frame counting and
   // the HOLD -> PENDING -> FLUSH -> HOLD progression.
   always_comb begin
      w_stateNext    = r_state;
      w_selectorNext = r_selector;
      w_nextModeNext = r_nextMode;
      w_flushCntNext = r_flushCnt;
      w_frameCntNext = r_frameCnt;
      w_errNext      = 1'b0;
      w_target       = r_nextMode;

      if (!auto_en_in) begin
         w_frameCntNext = 8'd0;
      end else if ((r_state == HOLD) && w_sof) begin
         w_frameCntNext = w_frameWrap ? 8'd0 : r_frameCnt + 8'd1;
      end

      case (r_state)
         HOLD: begin
            if (w_dirAccept) begin
               if (!w_dirLegal) begin
                  w_errNext = 1'b1;
               end else if (sel_req.sel_req_mode != r_selector) begin
                  w_nextModeNext = sel_req.sel_req_mode;
                  w_stateNext    = PENDING;
               end
            end else if (btn_pulse_in || w_autoReq) begin
               w_nextModeNext = advance(r_selector);
               w_stateNext    = PENDING;
            end
         end

         PENDING: begin
            if (w_dirAccept) begin
               if (w_dirLegal) begin
                  w_target = sel_req.sel_req_mode;
               end else begin
                  w_errNext = 1'b1;
               end
            end else if (btn_pulse_in) begin
               w_target = advance(r_nextMode);
            end
            w_nextModeNext = w_target;
            if (w_sof) begin
               w_selectorNext = w_target;
               w_flushCntNext = FLUSH_INIT;
               w_frameCntNext = 8'd0;
               w_stateNext    = FLUSH;
            end
         end

         FLUSH: begin
            w_flushCntNext = r_flushCnt - FW'(1);
            if (r_flushCnt <= FW'(1)) begin
               w_stateNext = HOLD;
            end
         end

         default: begin
            w_stateNext = HOLD;
         end
      endcase
   end

endmodule

// File: tb/tb_color_mode_sequencer.sv
// Testbench for color_mode_sequencer: directed scenarios followed by random
// traffic, every cycle compared against a frame-level reference model.
module tb_color_mode_sequencer;

   localparam int NM    = 7;
   localparam int FPM   = 2;
   localparam int FLUSH = 3;

   logic        clk_in;
   logic        rst_n_in;
   logic        rec_valid;
   logic [10:0] rec_hcount;
   logic [9:0]  rec_vcount;
   logic        btn_pulse_in;
   logic        auto_en_in;
   logic [2:0]  selector_out;
   logic        blank_out;
   logic        pending_out;
   logic        err_pulse_out;

   color_mode_sequencer_if selIf ();

   color_mode_sequencer #(
      .NUM_MODES       (NM),
      .FRAMES_PER_MODE (FPM),
      .FLUSH_CYCLES    (FLUSH)
   ) dut (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .rec_valid     (rec_valid),
      .rec_hcount    (rec_hcount),
      .rec_vcount    (rec_vcount),
      .btn_pulse_in  (btn_pulse_in),
      .auto_en_in    (auto_en_in),
      .sel_req       (selIf),
      .selector_out  (selector_out),
      .blank_out     (blank_out),
      .pending_out   (pending_out),
      .err_pulse_out (err_pulse_out)
   );

   // Free-running 10 ns clock.
   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model state: the mode on screen, the mode waiting for a frame
   // start (-1 when nothing waits), remaining blank cycles and frames shown.
   int mSel;
   int mPend;
   int mBlank;
   int mFrames;
   bit mReady;
   bit mErr;

   int pendCount;
   int blankCount;

   function automatic void modelReset();
      mSel    = 0;
      mPend   = -1;
      mBlank  = 0;
      mFrames = 0;
      mReady  = 1'b0;
      mErr    = 1'b0;
   endfunction

   function automatic void modelClock(input bit sof, input bit btn, input bit ae,
                                      input bit dv, input int dm);
      bit acc;
      bit legal;
      bit inFlush;
      bit autoFire;
      int nf;
      int target;
      acc      = dv && mReady;
      legal    = (dm < NM);
      inFlush  = (mBlank > 0);
      autoFire = sof && ae && !inFlush && (mPend < 0) && (mFrames == FPM - 1);
      nf       = mFrames;
      if (!ae) nf = 0;
      else if (sof && !inFlush && (mPend < 0)) nf = (mFrames == FPM - 1) ? 0 : mFrames + 1;
      if (inFlush) begin
         mBlank = mBlank - 1;
      end else if (mPend < 0) begin
         if (acc) begin
            if (legal && (dm != mSel)) mPend = dm;
         end else if (btn || autoFire) begin
            mPend = (mSel + 1) % NM;
         end
      end else begin
         target = mPend;
         if (acc) begin
            if (legal) target = dm;
         end else if (btn) begin
            target = (mPend + 1) % NM;
         end
         mPend = target;
         if (sof) begin
            mSel   = target;
            mPend  = -1;
            mBlank = FLUSH;
            nf     = 0;
         end
      end
      mFrames = nf;
      mReady  = (mBlank == 0);
      mErr    = acc && !legal;
   endfunction

   // Single comparison point: counts the test and reports any mismatch.
   task automatic checkValue(input string tag, input int observed, input int expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Compares every DUT output against the reference model.
   task automatic checkOutput();
      checkValue("selector", int'(selector_out), mSel);
      checkValue("blank", int'(blank_out), int'(mBlank > 0));
      checkValue("pending", int'(pending_out), int'(mPend >= 0));
      checkValue("err", int'(err_pulse_out), int'(mErr));
      checkValue("ready", int'(selIf.sel_req_ready), int'(mReady));
   endtask

   // Drives one cycle of inputs at the falling edge, advances the model on
   // the rising edge and checks the outputs just after it.
   task automatic applyStimulus(input bit v, input logic [10:0] hc, input logic [9:0] vc,
                                input bit btn, input bit dv, input logic [2:0] dm,
                                input bit ae);
      bit sof;
      @(negedge clk_in);
      rec_valid           = v;
      rec_hcount          = hc;
      rec_vcount          = vc;
      btn_pulse_in        = btn;
      selIf.sel_req_valid = dv;
      selIf.sel_req_mode  = dm;
      auto_en_in          = ae;
      sof = v && (hc == 11'd0) && (vc == 10'd0);
      @(posedge clk_in);
      if (!rst_n_in) modelReset();
      else modelClock(sof, btn, ae, dv, int'(dm));
      #1;
      checkOutput();
   endtask

   task automatic idleCycles(input int n, input bit ae);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 11'd17, 10'd3, 1'b0, 1'b0, 3'd0, ae);
   endtask

   task automatic sofCycle(input bit btn, input bit dv, input logic [2:0] dm, input bit ae);
      applyStimulus(1'b1, 11'd0, 10'd0, btn, dv, dm, ae);
   endtask

   initial begin
      rst_n_in            = 1'b0;
      rec_valid           = 1'b0;
      rec_hcount          = 11'd0;
      rec_vcount          = 10'd0;
      btn_pulse_in        = 1'b0;
      auto_en_in          = 1'b0;
      selIf.sel_req_valid = 1'b0;
      selIf.sel_req_mode  = 3'd0;
      modelReset();

      // Reset values, including ready held low while in reset.
      idleCycles(2, 1'b0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      idleCycles(1, 1'b0);
      checkValue("ready_after_reset", int'(selIf.sel_req_ready), 1);

      // One button press, frame start 100 cycles later.
      pendCount = 0;
      applyStimulus(1'b1, 11'd9, 10'd9, 1'b1, 1'b0, 3'd0, 1'b0);
      if (pending_out) pendCount++;
      for (int i = 0; i < 99; i++) begin
         idleCycles(1, 1'b0);
         if (pending_out) pendCount++;
      end
      checkValue("pend_before_sof", int'(selector_out), 0);
      sofCycle(1'b0, 1'b0, 3'd0, 1'b0);
      if (pending_out) pendCount++;
      checkValue("pend_len", pendCount, 100);
      checkValue("sel_after_btn", int'(selector_out), 1);
      blankCount = 0;
      if (blank_out) blankCount++;
      for (int i = 0; i < 5; i++) begin
         idleCycles(1, 1'b0);
         if (blank_out) blankCount++;
      end
      checkValue("blank_len", blankCount, 3);

      // Wrap from the last mode back to mode 0.
      applyStimulus(1'b1, 11'd4, 10'd2, 1'b0, 1'b1, 3'd6, 1'b0);
      sofCycle(1'b0, 1'b0, 3'd0, 1'b0);
      checkValue("sel_six", int'(selector_out), 6);
      idleCycles(4, 1'b0);
      applyStimulus(1'b1, 11'd4, 10'd2, 1'b1, 1'b0, 3'd0, 1'b0);
      sofCycle(1'b0, 1'b0, 3'd0, 1'b0);
      checkValue("sel_wrap", int'(selector_out), 0);
      idleCycles(4, 1'b0);

      // Direct request beats a simultaneous button press.
      applyStimulus(1'b1, 11'd4, 10'd2, 1'b1, 1'b1, 3'd4, 1'b0);
      sofCycle(1'b0, 1'b0, 3'd0, 1'b0);
      checkValue("sel_direct_prio", int'(selector_out), 4);
      idleCycles(4, 1'b0);

      // Illegal mode code: handshake completes, error pulse, nothing else.
      checkValue("ready_before_illegal", int'(selIf.sel_req_ready), 1);
      applyStimulus(1'b1, 11'd4, 10'd2, 1'b0, 1'b1, 3'd7, 1'b0);
      checkValue("err_pulse", int'(err_pulse_out), 1);
      checkValue("sel_after_illegal", int'(selector_out), 4);
      checkValue("pend_after_illegal", int'(pending_out), 0);
      idleCycles(1, 1'b0);
      checkValue("err_single", int'(err_pulse_out), 0);

      // Reset during FLUSH clears outputs without a clock edge.
      applyStimulus(1'b1, 11'd4, 10'd2, 1'b1, 1'b0, 3'd0, 1'b0);
      sofCycle(1'b0, 1'b0, 3'd0, 1'b0);
      checkValue("blank_before_reset", int'(blank_out), 1);
      #2;
      rst_n_in = 1'b0;
      modelReset();
      #1;
      checkValue("async_blank", int'(blank_out), 0);
      checkValue("async_sel", int'(selector_out), 0);
      checkOutput();
      idleCycles(2, 1'b0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      idleCycles(1, 1'b0);
      checkValue("ready_after_abort", int'(selIf.sel_req_ready), 1);

      // Auto-cycle with two frames per mode over six frame starts.
      for (int f = 1; f <= 6; f++) begin
         idleCycles(9, 1'b1);
         sofCycle(1'b0, 1'b0, 3'd0, 1'b1);
         if (f == 2) checkValue("auto_sof2", int'(selector_out), 0);
         if (f == 3) checkValue("auto_sof3", int'(selector_out), 1);
         if (f == 5) checkValue("auto_sof5", int'(selector_out), 1);
         if (f == 6) checkValue("auto_sof6", int'(selector_out), 2);
      end

      // Random traffic against the reference model.
      begin
         bit ae;
         ae = 1'b1;
         for (int i = 0; i < 4000; i++) begin
            int r;
            bit v;
            logic [10:0] hc;
            logic [9:0]  vc;
            bit btn;
            bit dv;
            logic [2:0] dm;
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
               v = 1'b1; hc = 11'd0; vc = 10'd0;
            end else if (r < 12) begin
               v = 1'b0; hc = 11'd0; vc = 10'd0;
            end else begin
               v  = 1'($urandom_range(0, 1));
               hc = 11'($urandom_range(0, 3));
               vc = 10'($urandom_range(0, 3));
            end
            btn = ($urandom_range(0, 9) == 0);
            dv  = ($urandom_range(0, 7) == 0);
            dm  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) ae = ~ae;
            applyStimulus(v, hc, vc, btn, dv, dm, ae);
         end
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/color_mode_sequencer.md
COLOR_MODE_SEQUENCER -- requirements
Module: color_mode_sequencer

Interface
REQ-001 Parameter NUM_MODES, default 7, number of legal selector codes (0..NUM_MODES-1).
REQ-002 Parameter FRAMES_PER_MODE, default 60, frames each mode is held in auto-cycle.
REQ-003 Parameter FLUSH_CYCLES, default 3, downstream colour-path latency to blank after a switch.
REQ-004 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_n_in  input  1  asynchronous active-low reset.
REQ-006 rec_valid  input  1  pixel-stream valid, same stream that feeds the colour-mode datapath.
REQ-007 rec_hcount  input  11  pixel column of the current stream beat.
REQ-008 rec_vcount  input  10  pixel row of the current stream beat.
REQ-009 btn_pulse_in  input  1  single-cycle request to advance to the next mode.
REQ-010 auto_en_in  input  1  level; enables automatic mode advance every FRAMES_PER_MODE frames.
REQ-011 sel_req_valid  input  1  direct mode-select request valid.
REQ-012 sel_req_mode  input  3  requested mode code.
REQ-013 sel_req_ready  output  1  direct request accepted this cycle when high with sel_req_valid.
REQ-014 selector_out  output  3  mode code driven to the colour-mode datapath.
REQ-015 blank_out  output  1  high while downstream pixels are stale after a switch.
REQ-016 pending_out  output  1  high while a mode change waits for a frame boundary.
REQ-017 err_pulse_out  output  1  single-cycle pulse on an illegal direct request.

Function
REQ-018 Frame start (SOF) is the cycle with rec_valid=1, rec_hcount=0, rec_vcount=0.
REQ-019 States: HOLD, PENDING, FLUSH.
REQ-020 HOLD: selector_out stable; a request (REQ-022) loads next_mode and moves to PENDING.
REQ-021 PENDING: pending_out=1; on SOF, selector_out<=next_mode, flush counter<=FLUSH_CYCLES, go to FLUSH.
REQ-022 Request sources, priority in same cycle: direct > button > auto; lower-priority sources that cycle are dropped.
REQ-023 sel_req_ready=1 only in HOLD and PENDING; a direct request in PENDING overwrites next_mode.
REQ-024 Button and auto requests in PENDING advance next_mode by one more (modulo NUM_MODES); in FLUSH they are dropped.
REQ-025 Advance = (selector_out+1) in HOLD, (next_mode+1) in PENDING, wrapping NUM_MODES-1 -> 0.
REQ-026 Direct request with sel_req_mode >= NUM_MODES: accepted (ready handshake completes), ignored, err_pulse_out=1 next cycle, state unchanged.
REQ-027 Direct request equal to current selector_out in HOLD: accepted, no state change, no blank.
REQ-028 FLUSH: blank_out=1 for exactly FLUSH_CYCLES cycles starting the cycle after the SOF that applied the switch, then HOLD.
REQ-029 Frame counter: 8-bit, increments on each SOF in HOLD while auto_en_in=1; at FRAMES_PER_MODE-1 the next SOF raises an auto request and clears the counter.
REQ-030 Frame counter clears on any applied switch and when auto_en_in=0.
REQ-031 Auto request and its SOF coincide: request lands in PENDING and is applied on the following SOF (one-frame lag, by design).
REQ-032 SOF coinciding with a direct request in PENDING: new mode applied on that SOF.
REQ-033 Stream timing inputs are used only for SOF detection; no pixel data passes through.

Reset
REQ-034 While rst_n_in=0: state HOLD, selector_out=0, next_mode=0, frame counter=0, blank_out=0, pending_out=0, err_pulse_out=0, sel_req_ready=0.
REQ-035 Reset asserted mid-PENDING or mid-FLUSH aborts the change immediately; after deassertion sel_req_ready=1 on the first clock edge.

Verification
REQ-036 Reset, then btn_pulse_in once, SOF 100 cycles later -> pending_out high 100 cycles, selector_out 0->1 on SOF, blank_out high exactly 3 cycles.
REQ-037 selector_out=6, button then SOF -> selector_out=0 (wrap).
REQ-038 Same cycle sel_req_mode=4 valid plus btn_pulse_in -> selector_out=4 after SOF, button ignored.
REQ-039 sel_req_mode=7 -> ready=1, err_pulse_out one cycle, selector_out and state unchanged.
REQ-040 auto_en_in=1, FRAMES_PER_MODE=2, 6 SOFs -> selector_out steps 0->1 on SOF 3, 1->2 on SOF 6.
REQ-041 rst_n_in low during FLUSH -> blank_out and selector_out 0 without waiting for a clock.
